mult_seq: RTL and testbench
===========================

// Module: mult_seq
// PURPOSE
//  Parametrised sequential shift-add multiplier. Supports unsigned and two's-complement
//  signed operands, selectable per operation. Operands are latched on start. Processes
//  one multiplier bit per clock and holds the 2*WIDTH product until the next start.
//  Sits beside the ALU as the multi-cycle MULT unit; the ALU control stalls on Idle/Done.
// PARAMETERS
//  WIDTH   16   operand width in bits (>=2); product is 2*WIDTH, counter is $clog2(WIDTH)
// PORTS
//  Clk            in   1        clock, rising edge
//  Reset          in   1        asynchronous, active-low reset (Reset=0 resets)
//  St             in   1        start request; sampled only while Idle=1
//  Signed         in   1        1 = two's-complement operands, 0 = unsigned; latched with St
//  Multiplicando  in   WIDTH    multiplicand; latched with St
//  Multiplicador  in   WIDTH    multiplier; latched with St
//  Produto        out  2*WIDTH  product register {A,Q}; valid from Done until next accepted St
//  Idle           out  1        1 = ready to accept St
//  Done           out  1        one-cycle pulse: Produto holds the final result
// BEHAVIOUR
//  Reset (async, any state): Idle=1, Done=0, Produto=0, count=0, state=IDLE.
//  Registers: A[WIDTH-1:0] (upper product), Q[WIDTH-1:0] (multiplier/lower product),
//   B[WIDTH-1:0] (multiplicand), S (signed flag), count.
//  States: IDLE, CALC, DONE.
//   IDLE : Idle=1. On St=1: A<=0, Q<=Multiplicador, B<=Multiplicando, S<=Signed,
//          count<=WIDTH-1, go to CALC. On St=0: stay in IDLE; Produto unchanged.
//   CALC : Idle=0. One step per cycle. When count==0, do the final step and go to DONE;
//          otherwise count<=count-1.
//   DONE : Done=1, Idle=0 for exactly one cycle; then go to IDLE unconditionally.
//  Step (WIDTH+1-bit arithmetic):
//   ext(x) = S ? sign-extend(x) : zero-extend(x).
//   If Q[0]==0: sum = ext(A).
//   Else if the step is the last one (count==0) and S==1: sum = ext(A) - ext(B).
//   Otherwise: sum = ext(A) + ext(B).
//   A <= sum[WIDTH:1]; Q <= {sum[0], Q[WIDTH-1:1]}.
//   Unsigned: sum[WIDTH] is the carry. Signed: sum[WIDTH] is the true sign (no overflow).
//  Latency: St sampled at edge T, Done high in the cycle after edge T+WIDTH, i.e. WIDTH+1
//   cycles after St. Throughput: one product per WIDTH+2 cycles, using St again in IDLE.
//  St during CALC or DONE is ignored and never queued.
//  Operand/Signed input changes after the start edge do not affect the result.
//  Produto = {A,Q} at all times; intermediate values are visible during CALC.
//  Consumers sample Produto only on Done or while Idle=1 after Done.
//  Reset during CALC or DONE aborts immediately: no Done pulse, Produto=0.
//  Special values: 0 x anything = 0. Signed most-negative x most-negative
//   = +2^(2*WIDTH-2), which fits and is exact.
// STRUCTURE
//  Shared package mult_pkg: state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2),
//   and a function to compute the count width from WIDTH.
//  Sub-module mult_addsub: combinational (WIDTH+1)-bit add/subtract with sign/zero
//   extension. Inputs: A, B, Sub, S. Output: sum[WIDTH:0].
//  Top level holds the FSM, the counter and the A/Q/B/S registers.
// TESTING (WIDTH=16 unless noted; check Done timing on every case)
//  1. Unsigned 0x0003*0x0005 -> Produto=0x0000000F; Done exactly 17 cycles after St,
//     Idle=0 over that span.
//  2. Unsigned 0xFFFF*0xFFFF -> 0xFFFE0001. Also 0x0000*0xFFFF -> 0x00000000.
//  3. Signed 0xFFFD*0x0005 (-3*5) -> 0xFFFFFFF1. Signed 0x8000*0x8000 -> 0x40000000.
//     Signed 0x7FFF*0x8000 -> 0xC0008000.
//  4. Hold St=1 continuously with new operands mid-CALC: the result uses the latched
//     operands. The next op starts only on the IDLE cycle after DONE, giving a period
//     of 18 cycles.
//  5. Drop Reset to 0 at CALC step 7 -> Idle=1, Done=0, Produto=0 asynchronously
//     (before the next edge). No Done pulse follows. A fresh 7*9 after release -> 63.
//  6. Build with WIDTH=8: signed 0x80*0x80 -> 0x4000; unsigned 0xFF*0x02 -> 0x01FE;
//     Done 9 cycles after St. Random signed and unsigned operands checked against a
//     behavioural '*' model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//  - State encoding of the control FSM.
//  - count_width(): width of the step counter for a given operand width.
package mult_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The counter has to hold WIDTH-1. At least one bit is always kept.
    function automatic int count_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor for one multiplier step.
// Ports:
//  a    in   WIDTH     upper partial product
//  b    in   WIDTH     addend (the multiplicand, or zero)
//  sub  in   1         1 = a - b, 0 = a + b
//  s    in   1         1 = sign-extend operands, 0 = zero-extend
//  sum  out  WIDTH+1   extended result; the MSB is the carry (unsigned) or the sign (signed)
module mult_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             s,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;

    assign ext_a = {s & a[WIDTH-1], a};
    assign ext_b = {s & b[WIDTH-1], b};
    assign sum   = sub ? (ext_a - ext_b) : (ext_a + ext_b);

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Handles unsigned and two's-complement operands, selected per operation.
// Ports:
//  Clk            in   1        clock, rising edge
//  Reset          in   1        asynchronous reset, active low
//  St             in   1        start request, honoured only while Idle=1
//  Signed         in   1        1 = two's-complement operands (latched with St)
//  Multiplicando  in   WIDTH    multiplicand (latched with St)
//  Multiplicador  in   WIDTH    multiplier (latched with St)
//  Produto        out  2*WIDTH  product register {A,Q}
//  Idle           out  1        ready to accept St
//  Done           out  1        one-cycle pulse when Produto holds the final result
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 St,
    input  logic                 Signed,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Idle,
    output logic                 Done
);

    localparam int CW = count_width(WIDTH);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [CW-1:0]    count;
    logic             last_step;
    logic [WIDTH-1:0] addend;
    logic             sub;
    logic [WIDTH:0]   sum;

    assign last_step = (count == '0);

    // A zero addend makes the adder return ext(A) when the multiplier bit is 0.
    assign addend = q[0] ? b : '0;
    // The MSB of a two's-complement multiplier carries negative weight,
    // so its partial product is subtracted.
    assign sub    = q[0] & s & last_step;

    mult_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (a),
        .b   (addend),
        .sub (sub),
        .s   (s),
        .sum (sum)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (St) next_state = CALC;
            CALC:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Idle = 1'b0;
        Done = 1'b0;
        case (state)
            IDLE:    Idle = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, shift-add steps and the step counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a     <= '0;
            q     <= '0;
            b     <= '0;
            s     <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (St) begin
                        a     <= '0;
                        q     <= Multiplicador;
                        b     <= Multiplicando;
                        s     <= Signed;
                        count <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    a <= sum[WIDTH:1];
                    q <= {sum[0], q[WIDTH-1:1]};
                    if (!last_step) begin
                        count <= count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Produto = {a, q};

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

    logic        Clk;
    logic        Reset;

    logic        st16, sg16, idle16, done16;
    logic [15:0] mcand16, mplier16;
    logic [31:0] prod16;

    logic        st8, sg8, idle8, done8;
    logic [7:0]  mcand8, mplier8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q16[$];
    logic [15:0] q8[$];

    mult_seq #(.WIDTH(16)) dut16 (
        .Clk           (Clk),
        .Reset         (Reset),
        .St            (st16),
        .Signed        (sg16),
        .Multiplicando (mcand16),
        .Multiplicador (mplier16),
        .Produto       (prod16),
        .Idle          (idle16),
        .Done          (done16)
    );

    mult_seq #(.WIDTH(8)) dut8 (
        .Clk           (Clk),
        .Reset         (Reset),
        .St            (st8),
        .Signed        (sg8),
        .Multiplicando (mcand8),
        .Multiplicador (mplier8),
        .Produto       (prod8),
        .Idle          (idle8),
        .Done          (done8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] model16(input logic sg, input logic [15:0] x, input logic [15:0] y);
        longint px;
        longint py;
        px = sg ? longint'($signed(x)) : longint'(x);
        py = sg ? longint'($signed(y)) : longint'(y);
        return 32'(px * py);
    endfunction

    function automatic logic [15:0] model8(input logic sg, input logic [7:0] x, input logic [7:0] y);
        longint px;
        longint py;
        px = sg ? longint'($signed(x)) : longint'(x);
        py = sg ? longint'($signed(y)) : longint'(y);
        return 16'(px * py);
    endfunction

    // Drive a start on the 16-bit unit; returns #1 after the accepting edge with St low.
    task automatic issue16(input logic sg, input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp);
        @(negedge Clk);
        st16 = 1'b1; sg16 = sg; mcand16 = x; mplier16 = y;
        q16.push_back(exp);
        @(posedge Clk); #1;
        st16 = 1'b0;
        mcand16 = ~x; mplier16 = ~y; sg16 = ~sg;
    endtask

    task automatic issue8(input logic sg, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        @(negedge Clk);
        st8 = 1'b1; sg8 = sg; mcand8 = x; mplier8 = y;
        q8.push_back(exp);
        @(posedge Clk); #1;
        st8 = 1'b0;
        mcand8 = ~x; mplier8 = ~y; sg8 = ~sg;
    endtask

    // Count edges until Done is seen (bounded); n = -1 on timeout.
    task automatic wait_done16(output int n, output bit idle_seen);
        n = -1;
        idle_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1;
            if (done16) begin
                n = i;
                break;
            end
            if (idle16) idle_seen = 1'b1;
        end
    endtask

    task automatic wait_done8(output int n, output bit idle_seen);
        n = -1;
        idle_seen = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge Clk); #1;
            if (done8) begin
                n = i;
                break;
            end
            if (idle8) idle_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        st16 = 0; sg16 = 0; mcand16 = '0; mplier16 = '0;
        st8 = 0; sg8 = 0; mcand8 = '0; mplier8 = '0;
        #3;
        n_checks++;
        if (idle16 !== 1'b1 || done16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags16: got idle=%b done=%b expected idle=1 done=0", idle16, done16);
        end
        n_checks++;
        if (prod16 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_prod16: got %h expected 00000000", prod16);
        end
        n_checks++;
        if (idle8 !== 1'b1 || done8 !== 1'b0 || prod8 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state8: got idle=%b done=%b prod=%h expected 1 0 0000", idle8, done8, prod8);
        end
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (idle16 !== 1'b1 || done16 !== 1'b0 || prod16 !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_after_release: got idle=%b done=%b prod=%h expected 1 0 0", idle16, done16, prod16);
        end
    endtask

    // Runs a list of operations on the 16-bit unit, checking latency, Idle and result.
    task automatic run_list16(input string tag, input logic sg[], input logic [15:0] xs[],
                              input logic [15:0] ys[], input logic [31:0] exps[]);
        int n;
        bit seen;
        logic [31:0] exp;
        for (int k = 0; k < xs.size(); k++) begin
            issue16(sg[k], xs[k], ys[k], exps[k]);
            wait_done16(n, seen);
            exp = q16.pop_front();
            n_checks++;
            if (n !== 16) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d edges expected 16", tag, k, n);
            end
            n_checks++;
            if (seen || idle16 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_idle_busy[%0d]: got idle during calc/done expected idle=0", tag, k);
            end
            n_checks++;
            if (prod16 !== exp) begin
                n_fail++;
                $display("FAIL %s_prod[%0d]: got %h expected %h", tag, k, prod16, exp);
            end
            @(posedge Clk); #1;
            n_checks++;
            if (done16 !== 1'b0 || idle16 !== 1'b1 || prod16 !== exp) begin
                n_fail++;
                $display("FAIL %s_hold[%0d]: got done=%b idle=%b prod=%h expected 0 1 %h",
                         tag, k, done16, idle16, prod16, exp);
            end
        end
    endtask

    task automatic test_unsigned();
        run_list16("unsigned",
                   '{1'b0, 1'b0, 1'b0, 1'b0},
                   '{16'h0003, 16'hFFFF, 16'h0000, 16'h1234},
                   '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h0000},
                   '{32'h0000000F, 32'hFFFE0001, 32'h00000000, 32'h00000000});
    endtask

    task automatic test_signed();
        run_list16("signed",
                   '{1'b1, 1'b1, 1'b1, 1'b1},
                   '{16'hFFFD, 16'h8000, 16'h7FFF, 16'hFFFF},
                   '{16'h0005, 16'h8000, 16'h8000, 16'hFFFF},
                   '{32'hFFFFFFF1, 32'h40000000, 32'hC0008000, 32'h00000001});
    endtask

    task automatic test_random16();
        logic        sg[];
        logic [15:0] xs[];
        logic [15:0] ys[];
        logic [31:0] es[];
        sg = new[6]; xs = new[6]; ys = new[6]; es = new[6];
        for (int k = 0; k < 6; k++) begin
            sg[k] = 1'($urandom_range(0, 1));
            xs[k] = 16'($urandom);
            ys[k] = 16'($urandom);
            es[k] = model16(sg[k], xs[k], ys[k]);
        end
        run_list16("rand16", sg, xs, ys, es);
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        bit seen;
        logic [31:0] exp;
        @(negedge Clk);
        st16 = 1'b1; sg16 = 1'b0; mcand16 = 16'd1000; mplier16 = 16'd300;
        q16.push_back(32'h000493E0);
        @(posedge Clk); #1;
        // St stays high; these operands must only be taken by the next operation
        sg16 = 1'b1; mcand16 = 16'hFFF9; mplier16 = 16'h0006;
        q16.push_back(32'hFFFFFFD6);
        wait_done16(n1, seen);
        exp = q16.pop_front();
        n_checks++;
        if (n1 !== 16 || prod16 !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d edges prod=%h expected 16 edges prod=%h", n1, prod16, exp);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (idle16 !== 1'b1 || done16 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got idle=%b done=%b expected 1 0", idle16, done16);
        end
        @(posedge Clk); #1;
        n_checks++;
        if (idle16 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: got idle=%b expected 0", idle16);
        end
        st16 = 1'b0;
        wait_done16(n2, seen);
        exp = q16.pop_front();
        n_checks++;
        if (n2 + 2 !== 18) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles expected 18", n2 + 2);
        end
        n_checks++;
        if (prod16 !== exp) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", prod16, exp);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        bit seen;
        bit done_seen;
        logic [31:0] exp;
        issue16(1'b0, 16'h1234, 16'h5678, 32'h06260060);
        q16.delete();
        repeat (6) @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (idle16 !== 1'b1 || done16 !== 1'b0 || prod16 !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_async: got idle=%b done=%b prod=%h expected 1 0 00000000", idle16, done16, prod16);
        end
        @(posedge Clk); #1;
        @(negedge Clk);
        Reset = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge Clk); #1;
            if (done16) done_seen = 1'b1;
        end
        n_checks++;
        if (done_seen || idle16 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_done: got done_seen=%b idle=%b expected 0 1", done_seen, idle16);
        end
        issue16(1'b0, 16'd7, 16'd9, 32'd63);
        wait_done16(n, seen);
        exp = q16.pop_front();
        n_checks++;
        if (n !== 16 || prod16 !== exp) begin
            n_fail++;
            $display("FAIL abort_fresh: got %0d edges prod=%h expected 16 edges prod=%h", n, prod16, exp);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_width8();
        int n;
        bit seen;
        logic sg;
        logic [7:0] x, y;
        logic [15:0] exp;
        for (int k = 0; k < 22; k++) begin
            if (k == 0) begin
                sg = 1'b1; x = 8'h80; y = 8'h80; exp = 16'h4000;
            end else if (k == 1) begin
                sg = 1'b0; x = 8'hFF; y = 8'h02; exp = 16'h01FE;
            end else begin
                sg = 1'($urandom_range(0, 1));
                x = 8'($urandom);
                y = 8'($urandom);
                exp = model8(sg, x, y);
            end
            issue8(sg, x, y, exp);
            wait_done8(n, seen);
            exp = q8.pop_front();
            n_checks++;
            if (n !== 8 || seen) begin
                n_fail++;
                $display("FAIL w8_timing[%0d]: got %0d edges idle_seen=%b expected 8 edges 0", k, n, seen);
            end
            n_checks++;
            if (prod8 !== exp) begin
                n_fail++;
                $display("FAIL w8_prod[%0d] sg=%b %h*%h: got %h expected %h", k, sg, x, y, prod8, exp);
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_random16();
        test_back_to_back();
        test_reset_abort();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
